div_operand_stage: RTL and testbench
====================================

# div_operand_stage

- Operand-preparation stage directly upstream of the `div` stage.
- Joins the dividend and divisor streams into pairs and buffers them in a 2-entry FIFO with registered outputs.
- Presents each pair to the divider as two lock-stepped producer streams, so divider inputs are never combinationally tied to the upstream sources.
- Optionally screens out zero divisors before they reach the divider.

## Interface
Parameters:
- `W_DIN0`, 16: dividend width in bits.
- `W_DIN1`, 16: divisor width in bits.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-low reset (asserted when 0).
- `din0`  dti_s_if.consumer  `W_DIN0`  dividend stream in.
- `din1`  dti_s_if.consumer  `W_DIN1`  divisor stream in.
- `dout0`  dti_s_if.producer  `W_DIN0`  dividend stream to the divider.
- `dout1`  dti_s_if.producer  `W_DIN1`  divisor stream to the divider.
- `zero_cnt`  output  16  dropped zero-divisor pair count; present only with `DIV_OPERAND_ZERO_DROP_EN`.

## Operation
Storage:
- Two entries, each holding {dividend, divisor}.
- State: `wr_ptr` (1 bit), `rd_ptr` (1 bit), `count` (0..2).

Join (pair accept):
- `accept = din0.valid & din1.valid & (count != 2)`.
- `din0.ready = din1.ready = accept`; the two inputs are always consumed in the same cycle.
- A lone valid on one input is never consumed.
- Input `eot` is ignored.

Push:
- On `accept`, the pair is written at `wr_ptr` and `wr_ptr` toggles.
- Exception: a zero-divisor pair dropped under the configuration macro (see Configuration).

Pop:
- `dout0.valid = dout1.valid = (count != 0)`.
- Data comes from the entry at `rd_ptr`.
- `pop = dout0.valid & dout0.ready & dout1.ready`; on `pop`, `rd_ptr` toggles.
- `dout0.eot = dout1.eot = 0`.

Count update:
- push only: +1.
- pop only: −1.
- push and pop in the same cycle: unchanged.
- Push with `count == 2` cannot occur, because `accept` is gated.
- Push into an empty FIFO with a simultaneous pop cannot occur, because pop requires `count != 0`.

Zero test:
- The divisor is zero when all `W_DIN1` bits are 0.
- The test is independent of signedness.

Reset (`rst` = 0, asynchronous):
- Clears `count`, both pointers, the stored data and `zero_cnt` to 0.
- All `valid` and `ready` outputs drop to 0 immediately.
- Any pair held mid-operation is discarded.
- Operation resumes on the first rising edge after `rst` returns to 1.

## Timing
- Latency: a pair accepted at edge N is visible on `dout*` from edge N (valid after N), i.e. 1 cycle from input handshake to output valid.
- Throughput: 1 pair/cycle sustained while the downstream is ready every cycle.
- Backpressure: when downstream stalls, the FIFO fills after 2 accepts; input ready then drops in the next cycle.
- Full release: at `count == 2`, a pop in cycle N re-enables `accept` in cycle N+1. There is no same-cycle full pass-through, because `ready` is derived only from registered `count`.
- Output stability: `dout*.data` and `valid` are driven directly from registers. They must hold stable while valid and not ready.
- Reset values:
  - `din0.ready`, `din1.ready`: 0.
  - `dout0.valid`, `dout1.valid`: 0.
  - `dout0.data`, `dout1.data`: 0.
  - `dout*.eot`: 0.
  - `zero_cnt`: 0.

## Configuration
`DIV_OPERAND_ZERO_DROP_EN` selects zero-divisor handling.

With the macro defined:
- A pair with a zero divisor is still handshaked (`ready` = 1 under `accept`) but is not written to the FIFO.
- `zero_cnt` increments by 1, saturating at 16'hFFFF.
- The dropped pair contributes nothing to `count` for that cycle; a same-cycle pop still decrements it.

With the macro undefined:
- The `zero_cnt` port and its logic are absent.
- Zero-divisor pairs are buffered and forwarded like any other pair.

## Test plan
1. **Reset, then single pair:** release reset; drive din0=100, din1=7, both valid; dout ready.
   - Required: `din*.ready` = 1 in cycle 0.
   - Required: `dout0`=100, `dout1`=7, `valid` = 1 in cycle 1 only.
2. **Back-to-back streaming:** 8 pairs (i, i+1) for i=0..7, `dout` ready constantly.
   - Required: one output per cycle, in order, no gaps after the first.
3. **Backpressure:** `dout` ready = 0 while 3 pairs are offered.
   - Required: 2 accepted, then `din*.ready` = 0 and `count` = 2.
   - Required: after ready = 1 for one cycle, the third pair is accepted the next cycle and order is preserved.
4. **Unbalanced inputs:** `din0.valid` = 1 for 5 cycles with `din1.valid` = 0.
   - Required: `din0.ready` = 0 throughout; no output.
   - Required: when `din1` goes valid, exactly one pair is emitted.
5. **Zero divisor:** pairs (9,0), (9,3).
   - With the macro: only (9,3) is output and `zero_cnt` = 1.
   - Without the macro: both pairs are output in order.
6. **Reset mid-operation:** with `count` = 2 and `dout` stalled, assert `rst` between edges.
   - Required: `dout*.valid` and `din*.ready` go to 0 without waiting for a clock edge.
   - Required: after release, no stale pairs appear.

Source files
------------

// File: rtl/div_operand_stage_if.sv
// Valid/ready data stream interface with end-of-transfer flag, used on both
// sides of the divider operand stage.
interface dti_s_if #(
  parameter int W = 16
);
  logic         valid;
  logic         ready;
  logic         eot;
  logic [W-1:0] data;

  modport producer (output valid, output data, output eot, input ready);
  modport consumer (input valid, input data, input eot, output ready);
endinterface

// File: rtl/div_operand_stage.sv
// Operand stage ahead of the divider: joins dividend/divisor streams into a
// 2-entry FIFO. Define DIV_OPERAND_ZERO_DROP_EN to drop and count zero divisors.
module div_operand_stage #(
  parameter int W_DIN0 = 16,
  parameter int W_DIN1 = 16
) (
  input  logic       clk,
  input  logic       rst,
  dti_s_if.consumer  din0,
  dti_s_if.consumer  din1,
  dti_s_if.producer  dout0,
  dti_s_if.producer  dout1
`ifdef DIV_OPERAND_ZERO_DROP_EN
  ,
  output logic [15:0] zero_cnt
`endif
);

  logic [W_DIN0-1:0] dividend_mem [2];
  logic [W_DIN1-1:0] divisor_mem  [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;

  logic accept;
  logic push;
  logic pop;
  logic divisor_zero;
  logic unused_eot;

  assign unused_eot   = din0.eot ^ din1.eot;
  assign divisor_zero = (din1.data == '0);

  // Ready is gated by rst so both inputs refuse pairs while reset is held.
  assign accept = rst & din0.valid & din1.valid & (count != 2'd2);

`ifdef DIV_OPERAND_ZERO_DROP_EN
  assign push = accept & ~divisor_zero;
`else
  assign push = accept;
`endif

  assign pop = (count != 2'd0) & dout0.ready & dout1.ready;

  assign din0.ready  = accept;
  assign din1.ready  = accept;
  assign dout0.valid = (count != 2'd0);
  assign dout1.valid = (count != 2'd0);
  assign dout0.data  = dividend_mem[rd_ptr];
  assign dout1.data  = divisor_mem[rd_ptr];
  assign dout0.eot   = 1'b0;
  assign dout1.eot   = 1'b0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr          <= 1'b0;
      rd_ptr          <= 1'b0;
      count           <= 2'd0;
      dividend_mem[0] <= '0;
      dividend_mem[1] <= '0;
      divisor_mem[0]  <= '0;
      divisor_mem[1]  <= '0;
    end else begin
      if (push) begin
        dividend_mem[wr_ptr] <= din0.data;
        divisor_mem[wr_ptr]  <= din1.data;
        wr_ptr               <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef DIV_OPERAND_ZERO_DROP_EN
  // Dropped pairs are still handshaked; only the counter records them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      zero_cnt <= 16'd0;
    end else if (accept && divisor_zero && (zero_cnt != 16'hFFFF)) begin
      zero_cnt <= zero_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_div_operand_stage.sv
// Directed testbench for div_operand_stage; expectations follow
// DIV_OPERAND_ZERO_DROP_EN when it is defined for the build.
module tb_div_operand_stage;

  logic clk;
  logic rst;
  int   n_compared;
  int   n_mismatched;

  dti_s_if #(.W(16)) din0_if ();
  dti_s_if #(.W(16)) din1_if ();
  dti_s_if #(.W(16)) dout0_if ();
  dti_s_if #(.W(16)) dout1_if ();

`ifdef DIV_OPERAND_ZERO_DROP_EN
  logic [15:0] zero_cnt;
`endif

  div_operand_stage #(.W_DIN0(16), .W_DIN1(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .din0  (din0_if),
    .din1  (din1_if),
    .dout0 (dout0_if),
    .dout1 (dout1_if)
`ifdef DIV_OPERAND_ZERO_DROP_EN
    ,
    .zero_cnt (zero_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pair(input logic v0, input logic v1,
                            input logic [15:0] d0, input logic [15:0] d1);
    din0_if.valid = v0;
    din1_if.valid = v1;
    din0_if.data  = d0;
    din1_if.data  = d1;
  endtask

  task automatic test_reset();
    drive_pair(1'b1, 1'b1, 16'd100, 16'd7);
    dout0_if.ready = 1'b1;
    dout1_if.ready = 1'b1;
    repeat (2) next_cycle();
    @(negedge clk);
    n_compared++; if (din0_if.ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_din0_ready: got %b want 0", din0_if.ready); end
    n_compared++; if (din1_if.ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_din1_ready: got %b want 0", din1_if.ready); end
    n_compared++; if (dout0_if.valid !== 1'b0 || dout1_if.valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_dout_valid: got %b%b want 00", dout0_if.valid, dout1_if.valid); end
    n_compared++; if (dout0_if.data !== 16'd0 || dout1_if.data !== 16'd0) begin n_mismatched++; $display("[TB] FAIL rst_dout_data: got %0d/%0d want 0/0", dout0_if.data, dout1_if.data); end
    n_compared++; if (dout0_if.eot !== 1'b0 || dout1_if.eot !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_dout_eot: got %b%b want 00", dout0_if.eot, dout1_if.eot); end
`ifdef DIV_OPERAND_ZERO_DROP_EN
    n_compared++; if (zero_cnt !== 16'd0) begin n_mismatched++; $display("[TB] FAIL rst_zero_cnt: got %0d want 0", zero_cnt); end
`endif
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    n_compared++; if (din0_if.ready !== 1'b1 || din1_if.ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL single_ready: got %b%b want 11", din0_if.ready, din1_if.ready); end
    n_compared++; if (dout0_if.valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL single_early_valid: got %b want 0", dout0_if.valid); end
    next_cycle();
    drive_pair(1'b0, 1'b0, 16'd0, 16'd0);
    @(negedge clk);
    n_compared++; if (dout0_if.valid !== 1'b1 || dout1_if.valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL single_valid: got %b%b want 11", dout0_if.valid, dout1_if.valid); end
    n_compared++; if (dout0_if.data !== 16'd100 || dout1_if.data !== 16'd7) begin n_mismatched++; $display("[TB] FAIL single_data: got %0d/%0d want 100/7", dout0_if.data, dout1_if.data); end
    next_cycle();
    @(negedge clk);
    n_compared++; if (dout0_if.valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL single_after_valid: got %b want 0", dout0_if.valid); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    dout0_if.ready = 1'b1;
    dout1_if.ready = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      if (k < 8) drive_pair(1'b1, 1'b1, 16'(k), 16'(k + 1));
      else       drive_pair(1'b0, 1'b0, 16'd0, 16'd0);
      @(negedge clk);
      if (k < 8) begin
        n_compared++; if (din0_if.ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL b2b_ready[%0d]: got %b want 1", k, din0_if.ready); end
      end
      if (k >= 1) begin
        n_compared++; if (dout0_if.valid !== 1'b1 || dout0_if.data !== 16'(k - 1) || dout1_if.data !== 16'(k)) begin
          n_mismatched++; $display("[TB] FAIL b2b_out[%0d]: got v=%b %0d/%0d want v=1 %0d/%0d", k, dout0_if.valid, dout0_if.data, dout1_if.data, k - 1, k);
        end
      end
      next_cycle();
    end
    @(negedge clk);
    n_compared++; if (dout0_if.valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL b2b_drain_valid: got %b want 0", dout0_if.valid); end
    next_cycle();
  endtask

  task automatic test_backpressure();
    logic [15:0] exp0 [9];
    logic [15:0] exp1 [9];
    logic        expv [9];
    logic        expr [9];
    logic        offer [9];
    logic        rdy  [9];
    exp0  = '{16'd0, 16'd20, 16'd20, 16'd20, 16'd20, 16'd21, 16'd21, 16'd22, 16'd0};
    exp1  = '{16'd0, 16'd2,  16'd2,  16'd2,  16'd2,  16'd3,  16'd3,  16'd4,  16'd0};
    expv  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    expr  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    offer = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    rdy   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int c = 0; c < 9; c++) begin
      if (c == 0)      drive_pair(offer[c], offer[c], 16'd20, 16'd2);
      else if (c == 1) drive_pair(offer[c], offer[c], 16'd21, 16'd3);
      else             drive_pair(offer[c], offer[c], 16'd22, 16'd4);
      dout0_if.ready = rdy[c];
      dout1_if.ready = rdy[c];
      @(negedge clk);
      n_compared++; if (din0_if.ready !== expr[c] || din1_if.ready !== expr[c]) begin n_mismatched++; $display("[TB] FAIL bp_ready[%0d]: got %b%b want %b", c, din0_if.ready, din1_if.ready, expr[c]); end
      n_compared++; if (dout0_if.valid !== expv[c]) begin n_mismatched++; $display("[TB] FAIL bp_valid[%0d]: got %b want %b", c, dout0_if.valid, expv[c]); end
      if (expv[c]) begin
        n_compared++; if (dout0_if.data !== exp0[c] || dout1_if.data !== exp1[c]) begin n_mismatched++; $display("[TB] FAIL bp_data[%0d]: got %0d/%0d want %0d/%0d", c, dout0_if.data, dout1_if.data, exp0[c], exp1[c]); end
      end
      if (c == 2) begin
        n_compared++; if (dut.count !== 2'd2) begin n_mismatched++; $display("[TB] FAIL bp_count_full: got %0d want 2", dut.count); end
      end
      next_cycle();
    end
  endtask

  task automatic test_unbalanced();
    dout0_if.ready = 1'b1;
    dout1_if.ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      drive_pair(1'b1, 1'b0, 16'd50, 16'd5);
      @(negedge clk);
      n_compared++; if (din0_if.ready !== 1'b0 || dout0_if.valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL unbal_idle[%0d]: got ready=%b valid=%b want 0/0", c, din0_if.ready, dout0_if.valid); end
      next_cycle();
    end
    drive_pair(1'b1, 1'b1, 16'd50, 16'd5);
    @(negedge clk);
    n_compared++; if (din0_if.ready !== 1'b1 || din1_if.ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL unbal_join_ready: got %b%b want 11", din0_if.ready, din1_if.ready); end
    next_cycle();
    drive_pair(1'b0, 1'b0, 16'd0, 16'd0);
    @(negedge clk);
    n_compared++; if (dout0_if.valid !== 1'b1 || dout0_if.data !== 16'd50 || dout1_if.data !== 16'd5) begin n_mismatched++; $display("[TB] FAIL unbal_out: got v=%b %0d/%0d want v=1 50/5", dout0_if.valid, dout0_if.data, dout1_if.data); end
    next_cycle();
    @(negedge clk);
    n_compared++; if (dout0_if.valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL unbal_single: got valid=%b want 0", dout0_if.valid); end
    next_cycle();
  endtask

  task automatic test_zero_divisor();
    dout0_if.ready = 1'b1;
    dout1_if.ready = 1'b1;
    drive_pair(1'b1, 1'b1, 16'd9, 16'd0);
    @(negedge clk);
    n_compared++; if (din0_if.ready !== 1'b1 || din1_if.ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL zero_ready: got %b%b want 11", din0_if.ready, din1_if.ready); end
    next_cycle();
    drive_pair(1'b1, 1'b1, 16'd9, 16'd3);
    @(negedge clk);
`ifdef DIV_OPERAND_ZERO_DROP_EN
    n_compared++; if (dout0_if.valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL zero_dropped: got valid=%b want 0", dout0_if.valid); end
`else
    n_compared++; if (dout0_if.valid !== 1'b1 || dout0_if.data !== 16'd9 || dout1_if.data !== 16'd0) begin n_mismatched++; $display("[TB] FAIL zero_forwarded: got v=%b %0d/%0d want v=1 9/0", dout0_if.valid, dout0_if.data, dout1_if.data); end
`endif
    next_cycle();
    drive_pair(1'b0, 1'b0, 16'd0, 16'd0);
    @(negedge clk);
    n_compared++; if (dout0_if.valid !== 1'b1 || dout0_if.data !== 16'd9 || dout1_if.data !== 16'd3) begin n_mismatched++; $display("[TB] FAIL zero_next: got v=%b %0d/%0d want v=1 9/3", dout0_if.valid, dout0_if.data, dout1_if.data); end
    next_cycle();
    @(negedge clk);
    n_compared++; if (dout0_if.valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL zero_drain: got valid=%b want 0", dout0_if.valid); end
`ifdef DIV_OPERAND_ZERO_DROP_EN
    n_compared++; if (zero_cnt !== 16'd1) begin n_mismatched++; $display("[TB] FAIL zero_cnt: got %0d want 1", zero_cnt); end
`endif
    next_cycle();
  endtask

  task automatic test_mid_reset();
    dout0_if.ready = 1'b0;
    dout1_if.ready = 1'b0;
    drive_pair(1'b1, 1'b1, 16'd30, 16'd6);
    next_cycle();
    drive_pair(1'b1, 1'b1, 16'd31, 16'd7);
    next_cycle();
    n_compared++; if (dout0_if.valid !== 1'b1 || dut.count !== 2'd2) begin n_mismatched++; $display("[TB] FAIL mid_full: got valid=%b count=%0d want 1/2", dout0_if.valid, dut.count); end
    #2;
    rst = 1'b0;
    #1;
    n_compared++; if (dout0_if.valid !== 1'b0 || dout1_if.valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mid_async_valid: got %b%b want 00", dout0_if.valid, dout1_if.valid); end
    n_compared++; if (din0_if.ready !== 1'b0 || din1_if.ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mid_async_ready: got %b%b want 00", din0_if.ready, din1_if.ready); end
    @(negedge clk);
    n_compared++; if (din0_if.ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mid_hold_ready: got %b want 0", din0_if.ready); end
    next_cycle();
    rst = 1'b1;
    drive_pair(1'b0, 1'b0, 16'd0, 16'd0);
    dout0_if.ready = 1'b1;
    dout1_if.ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_compared++; if (dout0_if.valid !== 1'b0 || dout0_if.data !== 16'd0) begin n_mismatched++; $display("[TB] FAIL mid_stale[%0d]: got v=%b d=%0d want v=0 d=0", c, dout0_if.valid, dout0_if.data); end
      next_cycle();
    end
    drive_pair(1'b1, 1'b1, 16'd40, 16'd8);
    next_cycle();
    drive_pair(1'b0, 1'b0, 16'd0, 16'd0);
    @(negedge clk);
    n_compared++; if (dout0_if.valid !== 1'b1 || dout0_if.data !== 16'd40 || dout1_if.data !== 16'd8) begin n_mismatched++; $display("[TB] FAIL mid_resume: got v=%b %0d/%0d want v=1 40/8", dout0_if.valid, dout0_if.data, dout1_if.data); end
    next_cycle();
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst          = 1'b0;
    din0_if.eot  = 1'b0;
    din1_if.eot  = 1'b0;
    drive_pair(1'b0, 1'b0, 16'd0, 16'd0);
    dout0_if.ready = 1'b0;
    dout1_if.ready = 1'b0;
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_unbalanced();
    test_zero_divisor();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
